// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Collects NUM_SRC asynchronous interrupt lines and presents them
//            to the CPU interrupt bus. Each line is synchronised, and its
//            rising edge is latched into a pending register. The pending
//            register is then masked and priority-encoded (the lowest index
//            wins). The result is offered with a valid/id/ack handshake.
//            Software reaches PEND / MASK / FORCE(STATUS) / LEVEL through a
//            small strobed register port.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            irq_src[NUM_SRC]      raw asynchronous interrupt lines
//            reg_we/reg_re         register write / read strobes
//            reg_addr[2]           0=PEND 1=MASK 2=FORCE/STATUS 3=LEVEL
//            reg_wdata[32]         write data (bits >= NUM_SRC ignored)
//            reg_rdata[32]         registered read data
//            irq_out[NUM_SRC]      registered pend & mask
//            irq_valid, irq_id[4]  highest-priority unmasked pending source
//            irq_ack               CPU accepts irq_id
// Options  : IRQ_LEVEL_EN - adds the LEVEL register at address 3. It allows
//            each source to be made level-sensitive. When the macro is
//            undefined, address 3 reads 0 and every source is edge-sensitive.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
  parameter int NUM_SRC     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic [NUM_SRC-1:0] irq_out,
  output logic               irq_valid,
  output logic [3:0]         irq_id,
  input  logic               irq_ack
);

  localparam logic [1:0] C_ADDR_PEND  = 2'd0;
  localparam logic [1:0] C_ADDR_MASK  = 2'd1;
  localparam logic [1:0] C_ADDR_FORCE = 2'd2;
  localparam logic [1:0] C_ADDR_LEVEL = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] irq_out_q, irq_out_d;
  logic               irq_valid_q, irq_valid_d;
  logic [3:0]         irq_id_q, irq_id_d;
  logic [31:0]        reg_rdata_q, reg_rdata_d;
  logic [NUM_SRC-1:0] level_val;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [NUM_SRC-1:0] src_sync;    // output of the last synchroniser stage
  logic [NUM_SRC-1:0] edge_det;    // one-cycle rising-edge pulses
  logic [NUM_SRC-1:0] wr_bits;     // write data trimmed to the source count
  logic [NUM_SRC-1:0] pend_w1c;    // software clear request
  logic [NUM_SRC-1:0] pend_force;  // software set request
  logic [NUM_SRC-1:0] ack_clr;     // clear from an accepted handshake
  logic [NUM_SRC-1:0] pend_vis;    // pending bits the CPU is allowed to see
  logic               unused_wdata;

  // Only the low NUM_SRC bits of the write data matter. Fold the whole bus
  // so that the ignored upper bits still have a visible sink.
  assign unused_wdata = ^reg_wdata;
  assign wr_bits      = reg_wdata[NUM_SRC-1:0];

  assign pend_w1c   = (reg_we && reg_addr == C_ADDR_PEND)  ? wr_bits : '0;
  assign pend_force = (reg_we && reg_addr == C_ADDR_FORCE) ? wr_bits : '0;

  // --------------------------------------------------------------------------
  // Synchroniser chain and edge detector
  // --------------------------------------------------------------------------
  always_comb begin
    sync_d[0] = irq_src;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign src_sync = sync_q[SYNC_STAGES-1];
  assign prev_d   = src_sync;
  assign edge_det = src_sync & ~prev_q;

  // --------------------------------------------------------------------------
  // Acknowledge decode: only the source that is currently presented is
  // cleared, and only while the handshake is actually offering it.
  // --------------------------------------------------------------------------
  always_comb begin
    ack_clr = '0;
    if (irq_ack && irq_valid_q) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (irq_id_q == 4'(i)) begin
          ack_clr[i] = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional level-sensitive sources
  // --------------------------------------------------------------------------
`ifdef IRQ_LEVEL_EN
  logic [NUM_SRC-1:0] level_q, level_d;

  assign level_d = (reg_we && reg_addr == C_ADDR_LEVEL) ? wr_bits : level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_val = level_q;
`else
  assign level_val = '0;
`endif

  // --------------------------------------------------------------------------
  // Pending register. For an edge source, a set request beats a
  // simultaneous clear, so a new edge is not lost when it coincides with
  // the ack of the previous one. A level source simply follows its
  // synchronised line. A FORCE write can still set it.
  // --------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (level_val[i]) begin
        pend_d[i] = src_sync[i] | pend_force[i];
      end else if (edge_det[i] || pend_force[i]) begin
        pend_d[i] = 1'b1;
      end else if (pend_w1c[i] || ack_clr[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  assign mask_d = (reg_we && reg_addr == C_ADDR_MASK) ? wr_bits : mask_q;

  // --------------------------------------------------------------------------
  // Output stage: one cycle behind pend/mask
  // --------------------------------------------------------------------------
  assign pend_vis    = pend_q & mask_q;
  assign irq_out_d   = pend_vis;
  assign irq_valid_d = |pend_vis;

  // Scan from the top down so that the lowest set index is the last to
  // assign. With nothing visible, the id stays 0.
  always_comb begin
    irq_id_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_vis[i]) begin
        irq_id_d = 4'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register read port. The value is sampled from the current flop
  // contents, so a read and a write in the same cycle return the value
  // from before the write. The data is held until the next read strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    reg_rdata_d = reg_rdata_q;
    if (reg_re) begin
      case (reg_addr)
        C_ADDR_PEND:  reg_rdata_d = 32'(pend_q);
        C_ADDR_MASK:  reg_rdata_d = 32'(mask_q);
        C_ADDR_FORCE: reg_rdata_d = {27'b0, irq_valid_q, irq_id_q};
        C_ADDR_LEVEL: reg_rdata_d = 32'(level_val);
        default:      reg_rdata_d = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev_q      <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      irq_out_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      reg_rdata_q <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      irq_out_q   <= irq_out_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      reg_rdata_q <= reg_rdata_d;
    end
  end

  assign irq_out   = irq_out_q;
  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign reg_rdata = reg_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Self-checking bench for interrupt_controller (NUM_SRC=16,
//            SYNC_STAGES=2). A transaction-level reference model predicts
//            every output each cycle. Directed scenarios add fixed
//            expectations, and a randomized phase follows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

  localparam int NUM_SRC     = 16;
  localparam int SYNC_STAGES = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] irq_src;
  logic               reg_we;
  logic               reg_re;
  logic [1:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;
  logic [NUM_SRC-1:0] irq_out;
  logic               irq_valid;
  logic [3:0]         irq_id;
  logic               irq_ack;

  always #5 clk = ~clk;

  interrupt_controller #(
    .NUM_SRC    (NUM_SRC),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .irq_out  (irq_out),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. The line history holds the irq_src value sampled on
  // each past clock edge, with hist[0] the most recent. A source reaches
  // the pend logic SYNC_STAGES edges after it is sampled.
  // --------------------------------------------------------------------------
  logic [15:0] m_hist [0:SYNC_STAGES];
  logic [15:0] m_pend, m_mask, m_level, m_out;
  logic        m_valid;
  logic [3:0]  m_id;
  logic [31:0] m_rdata;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= SYNC_STAGES; j++) m_hist[j] = '0;
    m_pend  = '0;
    m_mask  = '0;
    m_level = '0;
    m_out   = '0;
    m_valid = 1'b0;
    m_id    = '0;
    m_rdata = '0;
  endtask

  // Advance the model across the coming clock edge, using the inputs that
  // are currently driven.
  task automatic model_step();
    logic [15:0] sync_now, rose, set_b, w1c_b, ack_b, nxt, vis;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sync_now = m_hist[SYNC_STAGES-1];
    rose     = sync_now & ~m_hist[SYNC_STAGES];
    set_b    = (reg_we && reg_addr == 2'd2) ? reg_wdata[15:0] : 16'h0;
    w1c_b    = (reg_we && reg_addr == 2'd0) ? reg_wdata[15:0] : 16'h0;
    ack_b    = (irq_ack && m_valid) ? (16'(1) << m_id) : 16'h0;
    nxt      = (m_pend & ~(w1c_b | ack_b)) | rose | set_b;
`ifdef IRQ_LEVEL_EN
    nxt      = (nxt & ~m_level) | ((sync_now | set_b) & m_level);
`endif
    if (reg_re) begin
      case (reg_addr)
        2'd0:    m_rdata = {16'h0, m_pend};
        2'd1:    m_rdata = {16'h0, m_mask};
        2'd2:    m_rdata = {27'h0, m_valid, m_id};
`ifdef IRQ_LEVEL_EN
        default: m_rdata = {16'h0, m_level};
`else
        default: m_rdata = 32'h0;
`endif
      endcase
    end
    vis     = m_pend & m_mask;
    m_out   = vis;
    m_valid = (vis != 16'h0);
    m_id    = lowest_set(vis);
    m_pend  = nxt;
    if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata[15:0];
`ifdef IRQ_LEVEL_EN
    if (reg_we && reg_addr == 2'd3) m_level = reg_wdata[15:0];
`endif
    for (int j = SYNC_STAGES; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = irq_src;
  endtask

  // Run n clock cycles. Inputs change only on the falling edge, and every
  // output is compared with the model there.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("irq_out",   32'(irq_out),   32'(m_out));
      check("irq_valid", 32'(irq_valid), 32'(m_valid));
      check("irq_id",    32'(irq_id),    32'(m_id));
      check("reg_rdata", reg_rdata,      m_rdata);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    cyc(1);
    reg_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    reg_re   = 1'b1;
    reg_addr = a;
    cyc(1);
    reg_re   = 1'b0;
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    irq_src   = '0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    irq_ack   = 1'b0;
    model_reset();
    #1;
    check("rst_irq_out",   32'(irq_out),   32'h0);
    check("rst_irq_valid", 32'(irq_valid), 32'h0);
    check("rst_irq_id",    32'(irq_id),    32'h0);
    check("rst_rdata",     reg_rdata,      32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Edge latency: high before edge 0 -> pend after edge 2 -> valid after edge 3
    wr(2'd1, 32'h0000_FFFF);
    irq_src[5] = 1'b1;
    cyc(3);
    check("edge_not_yet_valid", 32'(irq_valid), 32'h0);
    cyc(1);
    check("edge_valid", 32'(irq_valid), 32'h1);
    check("edge_id",    32'(irq_id),    32'h5);
    ack_once();
    cyc(1);
    check("ack_clears", 32'(irq_valid), 32'h0);
    cyc(4);
    check("held_no_retrigger", 32'(irq_valid), 32'h0);
    rd(2'd0);
    check("held_pend_zero", reg_rdata, 32'h0);

    // Priority between sources 3 and 9
    wr(2'd2, 32'h0000_0208);
    cyc(1);
    check("prio_valid", 32'(irq_valid), 32'h1);
    check("prio_id3",   32'(irq_id),    32'h3);
    ack_once();
    cyc(1);
    check("prio_id9", 32'(irq_id), 32'h9);
    ack_once();
    cyc(1);
    check("prio_empty", 32'(irq_valid), 32'h0);

    // A masked source stays pending but is not presented
    wr(2'd1, 32'h0);
    irq_src[2] = 1'b1;
    cyc(4);
    check("mask_hidden", 32'(irq_valid), 32'h0);
    rd(2'd0);
    check("mask_pend_kept", reg_rdata, 32'h4);
    wr(2'd1, 32'h4);
    cyc(1);
    check("unmask_valid", 32'(irq_valid), 32'h1);
    check("unmask_id",    32'(irq_id),    32'h2);
    wr(2'd0, 32'h4);
    cyc(2);

    // Race: the ack of id 7 lands on the same edge as a new edge on source 7
    wr(2'd1, 32'h0000_FFFF);
    irq_src[7] = 1'b1;
    wr(2'd2, 32'h80);
    cyc(1);
    check("race_pre_id", 32'(irq_id), 32'h7);
    ack_once();
    cyc(2);
    check("race_valid", 32'(irq_valid), 32'h1);
    check("race_id",    32'(irq_id),    32'h7);
    rd(2'd0);
    check("race_pend", reg_rdata, 32'h80);
    wr(2'd0, 32'h80);
    cyc(2);

    // FORCE and STATUS
    wr(2'd2, 32'h8000);
    cyc(1);
    check("force_id", 32'(irq_id), 32'hF);
    rd(2'd2);
    check("status", reg_rdata, 32'h1F);
    wr(2'd0, 32'h8000);
    rd(2'd0);
    check("force_w1c", reg_rdata, 32'h0);

    // A read in the same cycle as a write to the same address returns the old value
    reg_re = 1'b1;
    wr(2'd1, 32'h1234_00F0);
    reg_re = 1'b0;
    check("rd_pre_write", reg_rdata, 32'h0000_FFFF);
    rd(2'd1);
    check("mask_upper_ignored", reg_rdata, 32'h0000_00F0);
    wr(2'd1, 32'h0000_FFFF);

`ifdef IRQ_LEVEL_EN
    wr(2'd3, 32'h2);
    irq_src[1] = 1'b1;
    cyc(4);
    wr(2'd0, 32'h2);
    cyc(1);
    rd(2'd0);
    check("level_held", reg_rdata & 32'h2, 32'h2);
    irq_src[1] = 1'b0;
    cyc(4);
    rd(2'd0);
    check("level_released", reg_rdata & 32'h2, 32'h0);
    wr(2'd3, 32'h0);
`else
    wr(2'd3, 32'h0000_FFFF);
    rd(2'd3);
    check("level_absent", reg_rdata, 32'h0);
`endif

    // Asynchronous reset with everything pending
    wr(2'd2, 32'h0000_FFFF);
    rd(2'd0);
    check("pre_rst_pend", reg_rdata, 32'h0000_FFFF);
    cyc(1);
    check("pre_rst_out", 32'(irq_out), 32'h0000_FFFF);
    rst_n = 1'b0;
    #1;
    check("async_rst_irq_out",   32'(irq_out),   32'h0);
    check("async_rst_irq_valid", 32'(irq_valid), 32'h0);
    check("async_rst_irq_id",    32'(irq_id),    32'h0);
    check("async_rst_rdata",     reg_rdata,      32'h0);
    model_reset();
    irq_src = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Randomized traffic against the model
    for (int t = 0; t < 800; t++) begin
      irq_src   = irq_src ^ 16'($urandom & $urandom & $urandom);
      reg_we    = ($urandom_range(0, 3) == 0);
      reg_re    = ($urandom_range(0, 1) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = $urandom;
      irq_ack   = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    reg_we  = 1'b0;
    reg_re  = 1'b0;
    irq_ack = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
